// File: rtl/fila_arbiter_if.sv
// Signal bundle between fila_arbiter, its two producers, its consumer and the fila queue.
// The slave modport is the arbiter; the master modport is the requester/queue side.
interface fila_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             p0_req;
   logic [WIDTH-1:0] p0_data;
   logic             p0_ack;
   logic             p1_req;
   logic [WIDTH-1:0] p1_data;
   logic             p1_ack;
   logic             c_req;
   logic             c_valid;
   logic [WIDTH-1:0] c_data;
   logic [WIDTH-1:0] fila_data_in;
   logic             fila_enqueue;
   logic             fila_dequeue;
   logic [WIDTH-1:0] fila_data_out;
   logic [7:0]       fila_len;
   logic             full;
   logic             empty;
   logic             busy;

   modport slave (
      input  p0_req, p0_data, p1_req, p1_data, c_req, fila_data_out, fila_len,
      output p0_ack, p1_ack, c_valid, c_data, fila_data_in, fila_enqueue, fila_dequeue,
             full, empty, busy
   );

   modport master (
      output p0_req, p0_data, p1_req, p1_data, c_req, fila_data_out, fila_len,
      input  p0_ack, p1_ack, c_valid, c_data, fila_data_in, fila_enqueue, fila_dequeue,
             full, empty, busy
   );
endinterface

// File: rtl/fila_arbiter.sv
// Round-robin arbiter sharing one fila queue between two producers and one consumer.
// Every operation is IDLE -> ENQ/DEQ -> WAIT -> IDLE, three cycles end to end.
module fila_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input logic           clk_10KHz,
   input logic           reset,
   fila_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StEnq, StDeq, StWait} state_e;
   typedef enum logic [1:0] {ReqP0, ReqP1, ReqC} req_e;

   state_e           state_q, state_d;
   req_e             rr_q, rr_d, op_q, op_d, grant_who;
   logic             grant_valid;
   logic             full, empty;
   logic [3:0]       elig;
   logic [WIDTH-1:0] hold_q, hold_d, c_data_q, c_data_d;

   function automatic req_e next_req(input req_e r);
      req_e n;
      case (r)
         ReqP0:   n = ReqP1;
         ReqP1:   n = ReqC;
         default: n = ReqP0;
      endcase
      return n;
   endfunction

   // Anything above DEPTH also counts as full, so producers are never granted then.
   always_comb begin
      full  = bus.fila_len >= 8'(DEPTH);
      empty = bus.fila_len == 8'd0;
      elig  = {1'b0, bus.c_req & ~empty, bus.p1_req & ~full, bus.p0_req & ~full};
   end

   always_comb begin
      req_e cand;
      cand        = rr_q;
      grant_valid = 1'b0;
      grant_who   = ReqP0;
      for (int i = 0; i < 3; i++) begin
         if (!grant_valid && elig[cand]) begin
            grant_valid = 1'b1;
            grant_who   = cand;
         end
         cand = next_req(cand);
      end
   end

   always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         rr_q     <= ReqP0;
         op_q     <= ReqP0;
         hold_q   <= '0;
         c_data_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         op_q     <= op_d;
         hold_q   <= hold_d;
         c_data_q <= c_data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      op_d     = op_q;
      hold_d   = hold_q;
      c_data_d = c_data_q;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               rr_d = next_req(grant_who);
               op_d = grant_who;
               if (grant_who == ReqC) begin
                  state_d = StDeq;
               end else begin
                  state_d = StEnq;
                  hold_d  = (grant_who == ReqP1) ? bus.p1_data : bus.p0_data;
               end
            end
         end
         StEnq: state_d = StWait;
         // fila pops on this edge, so its current head is the word being removed.
         StDeq: begin
            state_d  = StWait;
            c_data_d = bus.fila_data_out;
         end
         StWait: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.fila_enqueue = (state_q == StEnq);
      bus.fila_dequeue = (state_q == StDeq);
      bus.p0_ack       = (state_q == StEnq) && (op_q == ReqP0);
      bus.p1_ack       = (state_q == StEnq) && (op_q == ReqP1);
      bus.c_valid      = (state_q == StWait) && (op_q == ReqC);
      bus.busy         = (state_q != StIdle);
      bus.fila_data_in = hold_q;
      bus.c_data       = c_data_q;
      bus.full         = full;
      bus.empty        = empty;
   end
endmodule

// File: tb/tb_fila_arbiter.sv
// Directed bench for fila_arbiter: a behavioural fila queue, a scoreboard of expected
// acks/dequeues, and a monitor that pops and compares whenever the DUT pulses an output.
module tb_fila_arbiter;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 8;

   typedef struct packed {
      logic [1:0] kind;  // 0 = p0_ack, 1 = p1_ack, 2 = c_valid
      logic [7:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   p0_ack_cyc = 0;
   int   p1_ack_cyc = 0;
   exp_t sb[$];
   logic [7:0] fq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fila_arbiter_if #(.WIDTH(WIDTH)) bus ();

   fila_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_10KHz (clk),
      .reset     (rst_n),
      .bus       (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural fila: registered len/head, cleared together with the arbiter.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         bus.fila_len      <= 8'd0;
         bus.fila_data_out <= 8'h00;
      end else begin
         if (bus.fila_enqueue) fq.push_back(bus.fila_data_in);
         if (bus.fila_dequeue && fq.size() > 0) void'(fq.pop_front());
         bus.fila_len      <= 8'(fq.size());
         bus.fila_data_out <= (fq.size() > 0) ? fq[0] : 8'h00;
      end
   end

   task automatic expect_pop(input logic [1:0] kind, input logic [7:0] data, input string name);
      exp_t e;
      if (sb.size() == 0) begin
         check({name, "_unexpected"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         check({name, "_order"}, 32'(kind), 32'(e.kind));
         check({name, "_data"}, 32'(data), 32'(e.data));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.fila_enqueue) check("enq_deq_exclusive", 32'(bus.fila_dequeue), 32'd0);
         if (bus.fila_len > 8'(DEPTH)) check("len_over_depth", 32'(bus.fila_len), DEPTH);
         if (bus.p0_ack) begin
            expect_pop(2'd0, bus.fila_data_in, "p0_ack");
            check("p0_ack_with_enq", 32'(bus.fila_enqueue), 32'd1);
            p0_ack_cyc = cyc;
         end
         if (bus.p1_ack) begin
            expect_pop(2'd1, bus.fila_data_in, "p1_ack");
            check("p1_ack_with_enq", 32'(bus.fila_enqueue), 32'd1);
            p1_ack_cyc = cyc;
         end
         if (bus.c_valid) expect_pop(2'd2, bus.c_data, "c_valid");
      end
   end

   task automatic push_exp(input logic [1:0] kind, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic wait_pulse(input int which, input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         case (which)
            0:       seen = bus.p0_ack;
            1:       seen = bus.p1_ack;
            default: seen = bus.c_valid;
         endcase
      end
   endtask

   task automatic prod(input int idx, input logic [7:0] d);
      bit seen;
      @(posedge clk); #1;
      if (idx == 0) begin
         bus.p0_data = d;
         bus.p0_req  = 1'b1;
      end else begin
         bus.p1_data = d;
         bus.p1_req  = 1'b1;
      end
      wait_pulse(idx, 40, seen);
      check($sformatf("p%0d_ack_timeout", idx), 32'(seen), 32'd1);
      @(posedge clk); #1;
      if (idx == 0) bus.p0_req = 1'b0;
      else          bus.p1_req = 1'b0;
   endtask

   task automatic cons();
      bit seen;
      @(posedge clk); #1;
      bus.c_req = 1'b1;
      wait_pulse(2, 40, seen);
      check("c_valid_timeout", 32'(seen), 32'd1);
      @(posedge clk); #1;
      bus.c_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int prev;
      bus.p0_req = 1'b0; bus.p0_data = '0;
      bus.p1_req = 1'b0; bus.p1_data = '0;
      bus.c_req  = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_p0_ack", 32'(bus.p0_ack), 32'd0);
      check("rst_p1_ack", 32'(bus.p1_ack), 32'd0);
      check("rst_c_valid", 32'(bus.c_valid), 32'd0);
      check("rst_enq", 32'(bus.fila_enqueue), 32'd0);
      check("rst_deq", 32'(bus.fila_dequeue), 32'd0);
      check("rst_c_data", 32'(bus.c_data), 32'd0);
      check("rst_data_in", 32'(bus.fila_data_in), 32'd0);
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full", 32'(bus.full), 32'd0);
      rst_n = 1'b1;

      // Fill fila with 0x11..0x88 from p0 holding its request; then a 9th word must stall.
      for (int i = 0; i < 8; i++) push_exp(2'd0, 8'(8'h11 * (i + 1)));
      @(posedge clk); #1;
      bus.p0_data = 8'h11;
      bus.p0_req  = 1'b1;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         wait_pulse(0, 20, seen);
         check("fill_ack_timeout", 32'(seen), 32'd1);
         if (i > 0) check("fill_ack_spacing", 32'(cyc - prev), 32'd3);
         prev = cyc;
         @(posedge clk); #1;
         bus.p0_data = (i < 7) ? 8'(8'h11 * (i + 2)) : 8'h99;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("full_no_enq", 32'(bus.fila_enqueue), 32'd0);
      end
      check("fill_len", 32'(bus.fila_len), 32'd8);
      check("fill_full", 32'(bus.full), 32'd1);
      @(posedge clk); #1;
      bus.p0_req = 1'b0;

      // Full with all three requesting: consumer first, then p0 refills, p1 stays blocked.
      push_exp(2'd2, 8'h11);
      push_exp(2'd0, 8'hC3);
      fork
         cons();
         prod(0, 8'hC3);
         begin
            @(posedge clk); #1;
            bus.p1_data = 8'hD4;
            bus.p1_req  = 1'b1;
            repeat (15) @(posedge clk);
            #1 bus.p1_req = 1'b0;
         end
      join
      @(negedge clk);
      check("refill_len", 32'(bus.fila_len), 32'd8);
      check("refill_head", 32'(bus.fila_data_out), 32'h22);

      // Reset mid-ENQ: pulses must drop asynchronously.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_exp(2'd0, 8'hE5);
      @(posedge clk); #1;
      bus.p0_data = 8'hE5;
      bus.p0_req  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = bus.fila_enqueue;
      end
      check("enq_seen_before_reset", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_enq_drop", 32'(bus.fila_enqueue), 32'd0);
      check("async_ack_drop", 32'(bus.p0_ack), 32'd0);
      check("async_busy", 32'(bus.busy), 32'd0);
      check("async_data_in", 32'(bus.fila_data_in), 32'd0);
      bus.p0_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", 32'(bus.busy), 32'd0);

      // Simultaneous p0/p1 after reset: p0 first (pointer back at P0), p1 three cycles later.
      push_exp(2'd0, 8'hA1);
      push_exp(2'd1, 8'hB2);
      fork
         prod(0, 8'hA1);
         prod(1, 8'hB2);
      join
      check("rr_p1_after_p0", 32'(p1_ack_cyc - p0_ack_cyc), 32'd3);
      push_exp(2'd2, 8'hA1);
      push_exp(2'd2, 8'hB2);
      cons();
      cons();
      repeat (3) @(negedge clk);
      check("c_data_holds", 32'(bus.c_data), 32'hB2);

      // Consumer waits on empty, then is served right after p1 enqueues 0x5A.
      @(posedge clk); #1;
      bus.c_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("empty_no_deq", 32'(bus.fila_dequeue), 32'd0);
      end
      check("empty_flag", 32'(bus.empty), 32'd1);
      push_exp(2'd1, 8'h5A);
      push_exp(2'd2, 8'h5A);
      fork
         prod(1, 8'h5A);
         begin
            wait_pulse(2, 40, seen);
            check("c_after_empty_timeout", 32'(seen), 32'd1);
            @(posedge clk); #1;
            bus.c_req = 1'b0;
         end
      join

      // One-cycle p1 pulse while p0 is being served must be ignored.
      push_exp(2'd0, 8'h77);
      @(posedge clk); #1;
      bus.p0_data = 8'h77;
      bus.p0_req  = 1'b1;
      wait_pulse(0, 20, seen);
      check("p0_77_timeout", 32'(seen), 32'd1);
      @(posedge clk); #1;
      bus.p0_req  = 1'b0;
      bus.p1_data = 8'h66;
      bus.p1_req  = 1'b1;
      @(posedge clk); #1;
      bus.p1_req  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("dropped_req_no_enq", 32'(bus.fila_enqueue), 32'd0);
      end
      check("dropped_req_len", 32'(bus.fila_len), 32'd1);
      check("dropped_req_head", 32'(bus.fila_data_out), 32'h77);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
